// File: rtl/uart_rx_mon_if.sv
// Host-facing bundle of the UART receive monitor: serial line in, FIFO pop
// side out, plus sticky error/status flags.
// master = bench/host side, slave = receiver.
interface uart_rx_mon_if;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic       frame_err;
  logic       ovf_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx, rd_en, err_clr,
    input  rd_data, rd_vld, frame_err, ovf_err, parity_err, busy
  );

  modport slave (
    input  rx, rd_en, err_clr,
    output rd_data, rd_vld, frame_err, ovf_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_mon.sv
// UART receive monitor: 8N1 deserializer (LSB first) feeding a small
// first-word-fall-through byte FIFO, with sticky frame/overflow/parity flags.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing and enables
// parity_err; without it parity_err is tied 0.
module uart_rx_mon #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_mon_if.slave bus
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // receiver state
  logic        rx_q1, rx_s;
  state_t      state, state_n;
  logic [15:0] clk_cnt, cnt_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        wait_high, wait_n;
  logic        push, ferr_set;

  // fifo state
  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0][7:0]   mem;
  logic                         empty, full, pop, wr_ok, ovf_set;

  logic frame_err_q, ovf_err_q;

  // two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= bus.rx;
      rx_s  <= rx_q1;
    end
  end

  // frame FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_n;
      clk_cnt   <= cnt_n;
      bit_cnt   <= bit_n;
      shreg     <= sh_n;
      wait_high <= wait_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_set;
`endif

  // next-state: half-bit wait to centre on the start bit, then one full bit
  // period per sample; STOP returns to IDLE right at its sample point
  always_comb begin
    state_n  = state;
    cnt_n    = clk_cnt;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    wait_n   = wait_high;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        // after a bad stop bit the line may still be low (break); re-arm
        // only once it has returned high
        if (wait_high) begin
          if (rx_s) wait_n = 1'b0;
        end else if (!rx_s) begin
          state_n = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, shreg[7:1]};
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_n    = '0;
          perr_set = (rx_s != ^shreg);
          state_n  = STOP;
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
            wait_n   = 1'b1;
          end
        end else begin
          cnt_n = clk_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // fifo control: a pop frees a slot in the same cycle, so push+pop on a full
  // fifo is not an overflow
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign pop     = bus.rd_en & ~empty;
  assign wr_ok   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // byte storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      if (ferr_set)         frame_err_q <= 1'b1;
      else if (bus.err_clr) frame_err_q <= 1'b0;
      if (ovf_set)          ovf_err_q   <= 1'b1;
      else if (bus.err_clr) ovf_err_q   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  // sticky parity flag, same clear priority as the others
  always_ff @(posedge clk) begin
    if (rst)              parity_err_q <= 1'b0;
    else if (perr_set)    parity_err_q <= 1'b1;
    else if (bus.err_clr) parity_err_q <= 1'b0;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rd_vld    = ~empty;
  assign bus.rd_data   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign bus.frame_err = frame_err_q;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.busy      = (state != IDLE);

endmodule
